// File: rtl/rob_pkg.sv
// Shared types and tag helpers for the reorder buffer.
// Tags are entry index + 1; tag 0 means no lock.
package rob_pkg;

  localparam int TAG_W = 8;
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        we;
    logic [4:0]  rd;
    logic        is_br;
    logic [31:0] data;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;

  function automatic logic [TAG_W-1:0] tag_to_idx(
    input logic [TAG_W-1:0] tag
  );
    return tag - 1'b1;
  endfunction

  function automatic logic [TAG_W-1:0] idx_to_tag(
    input logic [TAG_W-1:0] idx
  );
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rob_lookup.sv
// One combinational operand-lookup port with CDB bypass.
// Out-of-range or zero tags read as not ready, data 0.
module rob_lookup #(
  parameter int DEPTH = 8,
  parameter int TAG_W = rob_pkg::TAG_W
) (
  input  rob_pkg::rob_entry_t entries [DEPTH],
  input  logic [TAG_W-1:0]    q_tag,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [31:0]         cdb_data,
  output logic                q_ready,
  output logic [31:0]         q_data
);
  import rob_pkg::*;

  localparam int IW = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] DEPTH_T = TAG_W'(DEPTH);

  logic [IW-1:0] idx;
  logic          in_range;
  rob_entry_t    e;

  assign in_range = (q_tag != NO_TAG) && (q_tag <= DEPTH_T);
  assign idx = IW'(tag_to_idx(q_tag));
  assign e = entries[idx];

  always_comb begin
    q_ready = 1'b0;
    q_data  = '0;
    unique case (1'b1)
      !in_range: ;
      (cdb_valid && cdb_tag == q_tag): begin
        q_ready = 1'b1;
        q_data  = cdb_data;
      end
      default: begin
        q_ready = e.valid && e.ready;
        q_data  = e.data;
      end
    endcase
  end

endmodule

// File: rtl/rob.sv
// In-order reorder buffer: allocate, CDB writeback, commit
// to the register file, and flush on a mispredicted branch.
module rob #(
  parameter int DEPTH = 8,
  parameter int TAG_W = rob_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic             alloc_we,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_is_br,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             cdb_mispredict,
  input  logic [31:0]      cdb_target,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_data,
  output logic [31:0]      q2_data,
  output logic             ROB_we,
  output logic [4:0]       reg_addr,
  output logic [31:0]      reg_data,
  output logic [TAG_W-1:0] reg_tag,
  output logic             br,
  output logic [31:0]      br_target
);
  import rob_pkg::*;

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [TAG_W-1:0] DEPTH_T = TAG_W'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  rob_entry_t    ent [DEPTH];
  rob_entry_t    head_e;
  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [IW-1:0] cdb_idx;
  logic [CW-1:0] count;
  logic          do_alloc;
  logic          do_wb;
  logic          do_commit;
  logic          flush;

  function automatic logic [IW-1:0] step(
    input logic [IW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign head_e    = ent[head];
  assign cdb_idx   = IW'(tag_to_idx(cdb_tag));
  assign full      = (count == FULL_C);
  assign alloc_tag = idx_to_tag(TAG_W'(tail));

  assign do_commit = head_e.valid && head_e.ready;
  assign flush     = do_commit && head_e.is_br
                   && head_e.mispredict;
  assign do_alloc  = alloc_valid && !full && !flush;
  assign do_wb     = cdb_valid && (cdb_tag != NO_TAG)
                   && (cdb_tag <= DEPTH_T)
                   && ent[cdb_idx].valid;

  // Commit clear is written last so it wins over a same-edge writeback.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_wb) begin
        ent[cdb_idx].ready      <= 1'b1;
        ent[cdb_idx].data       <= cdb_data;
        ent[cdb_idx].mispredict <= cdb_mispredict;
        ent[cdb_idx].target     <= cdb_target;
      end
      if (do_alloc) begin
        ent[tail] <= '{
          valid:      1'b1,
          ready:      1'b0,
          we:         alloc_we,
          rd:         alloc_rd,
          is_br:      alloc_is_br,
          data:       '0,
          mispredict: 1'b0,
          target:     '0
        };
        tail <= step(tail);
      end
      if (do_commit) begin
        ent[head].valid <= 1'b0;
        ent[head].ready <= 1'b0;
        head <= step(head);
      end
      unique case (1'b1)
        (do_alloc && !do_commit): count <= count + 1'b1;
        (do_commit && !do_alloc): count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ROB_we    <= 1'b0;
      br        <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
      reg_tag   <= '0;
      br_target <= '0;
    end else begin
      ROB_we <= do_commit && head_e.we;
      br     <= flush;
      if (do_commit) begin
        reg_addr <= head_e.rd;
        reg_data <= head_e.data;
        reg_tag  <= idx_to_tag(TAG_W'(head));
      end
      if (flush) br_target <= head_e.target;
    end
  end

  rob_lookup #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_q1 (
    .entries   (ent),
    .q_tag     (q1_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .q_ready   (q1_ready),
    .q_data    (q1_data)
  );

  rob_lookup #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_q2 (
    .entries   (ent),
    .q_tag     (q2_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .q_ready   (q2_ready),
    .q_data    (q2_data)
  );

endmodule
